// File: rtl/cfg_pkg.sv
// Shared types and default sizing for the serial configuration loader.
package cfg_pkg;

  localparam int unsigned DEF_WORD_W        = 320;
  localparam int unsigned DEF_NUM_WORDS     = 172;
  localparam int unsigned DEF_SETTLE_CYCLES = 10;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StShift  = 3'd1,
    StCommit = 3'd2,
    StSettle = 3'd3,
    StDone   = 3'd4,
    StError  = 3'd5
  } cfg_state_e;

  // Bits needed to hold every value 0..term; never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned term);
    return (term < 1) ? 1 : $clog2(term + 1);
  endfunction

endpackage

// File: rtl/cfg_deser.sv
// MSB-first deserializer: shifts valid bits in at the LSB and flags the cycle
// on which the final bit of a word arrives. o_word is the word as it will look
// after the current bit is shifted in, so the caller can capture it on that edge.
module cfg_deser
  import cfg_pkg::*;
#(
  parameter int unsigned WORD_W = DEF_WORD_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clr,
  input  logic              i_shift_en,
  input  logic              i_bit,
  output logic [WORD_W-1:0] o_word,
  output logic              o_word_done
);

  localparam int unsigned CNT_W = cnt_width(WORD_W);

  // Only WORD_W-1 bits are stored; the incoming bit completes the word.
  logic [WORD_W-2:0] r_shift;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_base;

  // A clear in the same cycle as a valid bit makes that bit bit 0 of a fresh word.
  always_comb begin
    w_cnt_base  = i_clr ? '0 : r_cnt;
    o_word      = {r_shift, i_bit};
    o_word_done = i_shift_en && (w_cnt_base == CNT_W'(WORD_W - 1));
  end

  // Shift register and bit counter.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (i_shift_en) begin
      r_shift <= o_word[WORD_W-2:0];
      r_cnt   <= o_word_done ? '0 : w_cnt_base + CNT_W'(1);
    end else if (i_clr) begin
      r_cnt <= '0;
    end
  end

endmodule

// File: rtl/cfg_serial_loader.sv
// Serial bitstream loader: assembles WORD_W-bit words from a serial stream,
// strobes each into the fabric with a one-hot enable, then waits a settle
// period before enabling the fabric flip-flops and reporting ready.
module cfg_serial_loader
  import cfg_pkg::*;
#(
  parameter int unsigned WORD_W        = DEF_WORD_W,
  parameter int unsigned NUM_WORDS     = DEF_NUM_WORDS,
  parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
  input  logic                 i_clock,
  input  logic                 i_rst_n,
  input  logic                 i_cfg_start,
  input  logic                 i_cfg_valid,
  input  logic                 i_cfg_bit,
  output logic [WORD_W-1:0]    o_configs_in,
  output logic [NUM_WORDS-1:0] o_configs_en,
  output logic                 o_ff_en,
  output logic                 o_rdy,
  output logic                 o_err
);

  localparam int unsigned IDX_W = cnt_width(NUM_WORDS - 1);
  localparam int unsigned SET_W = cnt_width(SETTLE_CYCLES);

  cfg_state_e        r_state;
  cfg_state_e        w_state_d;
  logic [IDX_W-1:0]  r_idx;
  logic [IDX_W-1:0]  w_idx_d;
  logic [SET_W-1:0]  r_settle;
  logic [SET_W-1:0]  w_settle_d;
  logic [WORD_W-1:0] r_configs_in;
  logic [WORD_W-1:0] w_configs_in_d;
  logic              r_ff_en;
  logic              w_ff_en_d;
  logic              r_rdy;
  logic              w_rdy_d;
  logic              r_err;
  logic              w_err_d;

  logic                 w_clr;
  logic                 w_shift_en;
  logic [WORD_W-1:0]    w_word;
  logic                 w_word_done;
  logic                 w_last_idx;
  logic [NUM_WORDS-1:0] w_configs_en;

  cfg_deser #(
    .WORD_W(WORD_W)
  ) u_deser (
    .i_clk      (i_clock),
    .i_rst_n    (i_rst_n),
    .i_clr      (w_clr),
    .i_shift_en (w_shift_en),
    .i_bit      (i_cfg_bit),
    .o_word     (w_word),
    .o_word_done(w_word_done)
  );

  assign w_last_idx = (r_idx == IDX_W'(NUM_WORDS - 1));

  // Next-state, deserializer control and the one-hot commit strobe.
  always_comb begin
    w_state_d    = r_state;
    w_idx_d      = r_idx;
    w_settle_d   = r_settle;
    w_ff_en_d    = r_ff_en;
    w_rdy_d      = r_rdy;
    w_err_d      = r_err;
    w_clr        = 1'b0;
    w_shift_en   = 1'b0;
    w_configs_en = '0;

    unique case (r_state)
      StIdle, StDone, StError: begin
        if (i_cfg_start) begin
          w_state_d  = StShift;
          w_idx_d    = '0;
          w_settle_d = '0;
          w_ff_en_d  = 1'b0;
          w_rdy_d    = 1'b0;
          w_err_d    = 1'b0;
          w_clr      = 1'b1;
          w_shift_en = i_cfg_valid;
        end else if (r_state == StDone) begin
          // ff_en was raised on entry; rdy follows one cycle later.
          w_rdy_d = 1'b1;
          if (i_cfg_valid) w_err_d = 1'b1;
        end
      end

      StShift: begin
        if (i_cfg_start) begin
          w_state_d = StError;
          w_err_d   = 1'b1;
          w_ff_en_d = 1'b0;
          w_rdy_d   = 1'b0;
        end else begin
          w_shift_en = i_cfg_valid;
          if (w_word_done) w_state_d = StCommit;
        end
      end

      StCommit: begin
        w_configs_en[r_idx] = 1'b1;
        if (i_cfg_start) begin
          w_state_d = StError;
          w_err_d   = 1'b1;
          w_ff_en_d = 1'b0;
          w_rdy_d   = 1'b0;
        end else if (w_last_idx) begin
          w_state_d  = StSettle;
          w_settle_d = '0;
          if (i_cfg_valid) w_err_d = 1'b1;
        end else begin
          // A bit arriving during commit already belongs to the next word.
          w_idx_d    = r_idx + IDX_W'(1);
          w_shift_en = i_cfg_valid;
          w_state_d  = w_word_done ? StCommit : StShift;
        end
      end

      StSettle: begin
        if (i_cfg_valid) w_err_d = 1'b1;
        if (r_settle == SET_W'(SETTLE_CYCLES - 1)) begin
          w_state_d = StDone;
          w_ff_en_d = 1'b1;
        end else begin
          w_settle_d = r_settle + SET_W'(1);
        end
      end

      default: begin
        w_state_d = StIdle;
      end
    endcase

    w_configs_in_d = w_word_done ? w_word : r_configs_in;
  end

  // State and output registers.
  always_ff @(posedge i_clock) begin
    if (!i_rst_n) begin
      r_state      <= StIdle;
      r_idx        <= '0;
      r_settle     <= '0;
      r_configs_in <= '0;
      r_ff_en      <= 1'b0;
      r_rdy        <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_idx        <= w_idx_d;
      r_settle     <= w_settle_d;
      r_configs_in <= w_configs_in_d;
      r_ff_en      <= w_ff_en_d;
      r_rdy        <= w_rdy_d;
      r_err        <= w_err_d;
    end
  end

  assign o_configs_in = r_configs_in;
  assign o_configs_en = w_configs_en;
  assign o_ff_en      = r_ff_en;
  assign o_rdy        = r_rdy;
  assign o_err        = r_err;

endmodule

// File: tb/tb_cfg_serial_loader.sv
// Directed bench for cfg_serial_loader with a small 4 x 8-bit bitstream.
module tb_cfg_serial_loader;

  localparam int unsigned W = 8;
  localparam int unsigned N = 4;
  localparam int unsigned S = 3;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         valid = 1'b0;
  logic         bitv  = 1'b0;
  logic [W-1:0] cfg_in;
  logic [N-1:0] cfg_en;
  logic         ff_en;
  logic         rdy;
  logic         err;

  int n_checks = 0;
  int n_errors = 0;

  logic [W-1:0] words [N] = '{8'hA5, 8'h3C, 8'hFF, 8'h01};

  always #5 clk = ~clk;

  cfg_serial_loader #(
    .WORD_W       (W),
    .NUM_WORDS    (N),
    .SETTLE_CYCLES(S)
  ) dut (
    .i_clock     (clk),
    .i_rst_n     (rst_n),
    .i_cfg_start (start),
    .i_cfg_valid (valid),
    .i_cfg_bit   (bitv),
    .o_configs_in(cfg_in),
    .o_configs_en(cfg_en),
    .o_ff_en     (ff_en),
    .o_rdy       (rdy),
    .o_err       (err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sends one word MSB first; on gap, an idle cycle precedes every bit but the start bit.
  task automatic send_word(input logic [W-1:0] w, input int idx, input bit first, input bit gap);
    for (int i = W - 1; i >= 0; i--) begin
      if (gap && !(first && i == W - 1)) begin
        start = 1'b0;
        valid = 1'b0;
        bitv  = 1'b0;
        tick();
        chk("gap_en", 64'(cfg_en), 64'(0));
      end
      start = first && (i == W - 1);
      valid = 1'b1;
      bitv  = w[i];
      tick();
      start = 1'b0;
      valid = 1'b0;
      if (first && i == W - 1) begin
        chk("start_ff_en", 64'(ff_en), 64'(0));
        chk("start_rdy", 64'(rdy), 64'(0));
        chk("start_err", 64'(err), 64'(0));
      end
      if (i > 0) begin
        chk("mid_en", 64'(cfg_en), 64'(0));
      end else begin
        chk("strobe", 64'(cfg_en), 64'(1) << idx);
        chk("word", 64'(cfg_in), 64'(w));
      end
    end
  endtask

  // Called right after the final strobe is observed; checks settle timing.
  task automatic finish_load(input bit extra);
    start = 1'b0;
    valid = 1'b0;
    tick();
    chk("settle1_ff_en", 64'(ff_en), 64'(0));
    chk("settle1_err", 64'(err), 64'(0));
    if (extra) begin
      valid = 1'b1;
      bitv  = 1'b1;
    end
    tick();
    valid = 1'b0;
    chk("settle2_ff_en", 64'(ff_en), 64'(0));
    chk("settle2_err", 64'(err), 64'(extra));
    tick();
    chk("settle3_ff_en", 64'(ff_en), 64'(0));
    tick();
    chk("ff_en_rise", 64'(ff_en), 64'(1));
    chk("rdy_lag", 64'(rdy), 64'(0));
    tick();
    chk("rdy_rise", 64'(rdy), 64'(1));
    chk("done_ff_en", 64'(ff_en), 64'(1));
    chk("done_en", 64'(cfg_en), 64'(0));
    chk("done_err", 64'(err), 64'(extra));
    chk("done_word", 64'(cfg_in), 64'(words[N-1]));
  endtask

  task automatic load(input bit gap, input bit extra);
    for (int k = 0; k < int'(N); k++) send_word(words[k], k, k == 0, gap);
    finish_load(extra);
  endtask

  initial begin
    // Reset state
    rst_n = 1'b0;
    tick();
    tick();
    chk("rst_word", 64'(cfg_in), 64'(0));
    chk("rst_en", 64'(cfg_en), 64'(0));
    chk("rst_ff_en", 64'(ff_en), 64'(0));
    chk("rst_rdy", 64'(rdy), 64'(0));
    chk("rst_err", 64'(err), 64'(0));
    rst_n = 1'b1;

    // Valid in idle is ignored
    valid = 1'b1;
    bitv  = 1'b1;
    tick();
    tick();
    valid = 1'b0;
    chk("idle_valid_err", 64'(err), 64'(0));
    chk("idle_valid_word", 64'(cfg_in), 64'(0));

    // Contiguous load
    load(1'b0, 1'b0);

    // Gapped load restarted from done
    load(1'b1, 1'b0);

    // Start after two words aborts into error
    send_word(words[0], 0, 1'b1, 1'b0);
    send_word(words[1], 1, 1'b0, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("abort_err", 64'(err), 64'(1));
    chk("abort_ff_en", 64'(ff_en), 64'(0));
    chk("abort_en", 64'(cfg_en), 64'(0));
    chk("abort_word", 64'(cfg_in), 64'(words[1]));
    valid = 1'b1;
    tick();
    valid = 1'b0;
    chk("error_valid_err", 64'(err), 64'(1));
    chk("error_valid_en", 64'(cfg_en), 64'(0));
    load(1'b0, 1'b0);

    // Reset in the middle of the third word
    send_word(words[0], 0, 1'b1, 1'b0);
    send_word(words[1], 1, 1'b0, 1'b0);
    for (int i = W - 1; i >= W - 3; i--) begin
      valid = 1'b1;
      bitv  = words[2][i];
      tick();
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    valid = 1'b0;
    chk("midrst_word", 64'(cfg_in), 64'(0));
    chk("midrst_en", 64'(cfg_en), 64'(0));
    chk("midrst_ff_en", 64'(ff_en), 64'(0));
    chk("midrst_rdy", 64'(rdy), 64'(0));
    chk("midrst_err", 64'(err), 64'(0));
    load(1'b0, 1'b0);

    // Extra bit during settle flags error, ready still on schedule
    load(1'b0, 1'b1);

    // Valid during the final commit flags error
    for (int k = 0; k < int'(N); k++) send_word(words[k], k, k == 0, 1'b0);
    valid = 1'b1;
    tick();
    valid = 1'b0;
    chk("last_commit_err", 64'(err), 64'(1));
    chk("last_commit_en", 64'(cfg_en), 64'(0));
    tick();
    tick();
    chk("last_commit_ff_en_low", 64'(ff_en), 64'(0));
    tick();
    chk("last_commit_ff_en", 64'(ff_en), 64'(1));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cfg_serial_loader.md
CFG_SERIAL_LOADER -- requirements
Module: cfg_serial_loader

Interface
REQ-001 Parameter WORD_W, default 320: width of one configuration word (configs_in).
REQ-002 Parameter NUM_WORDS, default 172: number of words per bitstream (configs_en width).
REQ-003 Parameter SETTLE_CYCLES, default 10: idle cycles between the last word strobe and ff_en assertion.
REQ-004 clock  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset; synchronous, active-low.
REQ-006 cfg_start  input  1  single-cycle pulse that begins a bitstream load.
REQ-007 cfg_valid  input  1  cfg_bit is valid this cycle.
REQ-008 cfg_bit  input  1  serial bitstream data, MSB of each word first.
REQ-009 configs_in  output  WORD_W  assembled word presented to the fabric.
REQ-010 configs_en  output  NUM_WORDS  one-hot word-write strobe; bit k selects word k.
REQ-011 ff_en  output  1  fabric flip-flop enable, high once configuration is complete.
REQ-012 rdy  output  1  fabric configured and running.
REQ-013 err  output  1  sticky protocol error flag.

Function
REQ-014 FSM states SHALL be IDLE, SHIFT, COMMIT, SETTLE, DONE, ERROR.
REQ-015 IDLE/DONE/ERROR + cfg_start -> SHIFT; bit counter, word index cleared; ff_en, rdy, err cleared in the same edge.
REQ-016 SHIFT: each cfg_valid cycle shifts cfg_bit into LSB of a WORD_W shift register (earlier bits move toward MSB); cycles without cfg_valid hold state.
REQ-017 On the WORD_W-th valid bit -> COMMIT; configs_in SHALL take the full word on that edge (latency 1 cycle after last bit).
REQ-018 COMMIT (exactly one cycle): configs_en[word index] = 1, all other bits 0; configs_in stable for that cycle and held until the next commit.
REQ-019 configs_en SHALL be all-zero in every state other than COMMIT.
REQ-020 After COMMIT: word index < NUM_WORDS-1 -> index+1, SHIFT; index = NUM_WORDS-1 -> SETTLE.
REQ-021 cfg_valid during COMMIT SHALL be accepted as bit 0 of the next word (no bit dropped); during COMMIT of the final word it SHALL set err.
REQ-022 SETTLE counts SETTLE_CYCLES cycles, then -> DONE with ff_en = 1; rdy = 1 exactly one cycle after ff_en rises.
REQ-023 DONE holds ff_en = rdy = 1 until reset or cfg_start.
REQ-024 cfg_start in SHIFT or COMMIT -> ERROR: err = 1, ff_en = rdy = 0, configs_en = 0, configs_in held.
REQ-025 cfg_valid in SETTLE or DONE SHALL set err but not alter ff_en, rdy or state.
REQ-026 cfg_valid in IDLE and ERROR SHALL be ignored.
REQ-027 cfg_start and cfg_valid in the same cycle from IDLE/DONE/ERROR: cfg_bit is taken as bit 0 of word 0.
REQ-028 Counters SHALL be sized $clog2 of their terminal value + 1 and never wrap within a load.

Reset
REQ-029 rst low at a clock edge SHALL force IDLE, configs_in = 0, configs_en = 0, ff_en = 0, rdy = 0, err = 0, counters = 0, regardless of state (including mid-load).
REQ-030 No output SHALL depend on rst combinationally; the first post-reset cycle presents reset values.

Structure
REQ-031 FSM state enum and default WORD_W/NUM_WORDS/SETTLE_CYCLES constants SHALL live in shared package cfg_pkg.
REQ-032 Single sub-module cfg_deser (WORD_W shift register + bit counter, word_done pulse); FSM, word index, one-hot decode and settle counter in the top.

Verification
REQ-033 WORD_W=8, NUM_WORDS=4, SETTLE_CYCLES=3; start, stream 0xA5,0x3C,0xFF,0x01 contiguous -> configs_en 0001,0010,0100,1000 one cycle each with configs_in equal to each word; ff_en 4 cycles after last strobe, rdy 1 cycle later.
REQ-034 Same stream with cfg_valid low every other cycle -> identical words/strobes, only timing stretched; err = 0.
REQ-035 cfg_start after 2 words -> ERROR, err = 1, ff_en = 0; new start + full stream -> err clears, rdy = 1.
REQ-036 rst low for 1 cycle mid-word 3 -> all outputs 0 next cycle; subsequent full load succeeds.
REQ-037 Extra valid bit after word 3 during SETTLE -> err = 1, rdy still asserts on schedule.
REQ-038 Default parameters, 172 random 320-bit words from a file -> 172 strobes in index order, each configs_in matching the file, rdy = 1.
